// File: rtl/rbot_move_pkg.sv
// Shared types for the cube move sequencer: face indices, FSM states and the
// steps-per-move helper.
package rbot_move_pkg;

    localparam int unsigned RIGHT = 0;
    localparam int unsigned UP    = 1;
    localparam int unsigned FRONT = 2;
    localparam int unsigned LEFT  = 3;
    localparam int unsigned BACK  = 4;
    localparam int unsigned DOWN  = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP_HI,
        STEP_LO,
        SETTLE,
        DONE
    } seq_state_e;

    // A half turn is two quarter turns worth of step pulses.
    function automatic int unsigned move_steps(input logic half, input int unsigned quarter_steps);
        return half ? 2 * quarter_steps : quarter_steps;
    endfunction

endpackage

// File: rtl/face_move_sequencer_step_phase_timer.sv
// Loadable down-counter with a one-cycle expiry; define STEPPER_RAMP_EN to
// compile in the per-move acceleration ramp for the step half period.
module step_phase_timer #(
    parameter int unsigned STEP_HALF_PERIOD = 31250,
    parameter int unsigned RAMP_START_HALF  = 125000,
    parameter int unsigned RAMP_DEC         = 6250,
    parameter int unsigned PH_W             = 17
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            load_step,
    input  logic [PH_W-1:0] load_val,
    input  logic            ramp_rst,
    input  logic            ramp_adv,
    output logic            expired_c
);

    logic [PH_W-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;
    logic [PH_W-1:0] half_sel_c;
    logic [PH_W-1:0] load_len_c;

`ifdef STEPPER_RAMP_EN
    localparam int unsigned RAMP_FIRST =
        (RAMP_START_HALF > STEP_HALF_PERIOD) ? RAMP_START_HALF : STEP_HALF_PERIOD;

    logic [PH_W-1:0] half_q, half_d;
    logic [PH_W-1:0] half_dec_c;

    // Saturating decrement: never drops below the cruise half period.
    always_comb begin
        half_dec_c = PH_W'(STEP_HALF_PERIOD);
        if (32'(half_q) >= STEP_HALF_PERIOD + RAMP_DEC) begin
            half_dec_c = half_q - PH_W'(RAMP_DEC);
        end
        half_sel_c = half_q;
        if (ramp_rst) begin
            half_sel_c = PH_W'(RAMP_FIRST);
        end else if (ramp_adv) begin
            half_sel_c = half_dec_c;
        end
        half_d = half_sel_c;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            half_q <= PH_W'(RAMP_FIRST);
        end else begin
            half_q <= half_d;
        end
    end
`else
    logic unused_ramp;
    assign unused_ramp = ^{ramp_rst, ramp_adv, 32'(RAMP_START_HALF), 32'(RAMP_DEC)};
    assign half_sel_c  = PH_W'(STEP_HALF_PERIOD);
`endif

    always_comb begin
        load_len_c = load_step ? half_sel_c : load_val;
        cnt_d      = cnt_q;
        run_d      = run_q;
        if (load) begin
            cnt_d = (load_len_c == '0) ? '0 : load_len_c - PH_W'(1);
            run_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PH_W'(1);
        end else begin
            run_d = 1'b0;
        end
    end

    assign expired_c = run_q & (cnt_q == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/face_move_sequencer.sv
// Turns one cube move at a time into shared step/dir pulses and a one-hot
// face enable. STEPPER_RAMP_EN selects the accelerating step ramp.
module face_move_sequencer
    import rbot_move_pkg::*;
#(
    parameter int unsigned NUM_FACES        = 6,
    parameter int unsigned QUARTER_STEPS    = 50,
    parameter int unsigned STEP_HALF_PERIOD = 31250,
    parameter int unsigned RAMP_START_HALF  = 125000,
    parameter int unsigned RAMP_DEC         = 6250,
    parameter int unsigned EN_SETUP         = 10,
    parameter int unsigned SETTLE_CYCLES    = 10,
    localparam int unsigned FACE_W          = (NUM_FACES > 1) ? $clog2(NUM_FACES) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 disable_steppers,
    input  logic                 move_valid,
    input  logic [FACE_W-1:0]    move_face,
    input  logic                 move_ccw,
    input  logic                 move_half,
    output logic                 move_ready,
    output logic                 move_done,
    output logic                 move_err,
    output logic                 move_aborted,
    output logic                 dir_pin,
    output logic                 step_pin,
    output logic [NUM_FACES-1:0] en_pins
);

    localparam int unsigned STEP_W   = $clog2(2 * QUARTER_STEPS + 1);
    localparam int unsigned HALF_MAX =
        (RAMP_START_HALF > STEP_HALF_PERIOD) ? RAMP_START_HALF : STEP_HALF_PERIOD;
    localparam int unsigned WAIT_MAX = (EN_SETUP > SETTLE_CYCLES) ? EN_SETUP : SETTLE_CYCLES;
    localparam int unsigned LEN_MAX  = (HALF_MAX > WAIT_MAX) ? HALF_MAX : WAIT_MAX;
    localparam int unsigned PH_W     = $clog2(LEN_MAX + 1);

    seq_state_e           state_q, state_d;
    logic [FACE_W-1:0]    face_q, face_d;
    logic                 dir_q, dir_d;
    logic                 turn_half_q, turn_half_d;
    logic [STEP_W-1:0]    steps_q, steps_d;
    logic [NUM_FACES-1:0] en_q, en_d;
    logic                 step_q, step_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 abort_q, abort_d;

    logic [STEP_W-1:0]    step_tgt_c;
    logic [STEP_W-1:0]    steps_inc_c;
    logic                 tmr_load_c, tmr_load_step_c, tmr_exp_c;
    logic                 ramp_rst_c, ramp_adv_c;
    logic [PH_W-1:0]      tmr_val_c;

    assign move_ready = (state_q == IDLE) & ~disable_steppers & ~reset;

    step_phase_timer #(
        .STEP_HALF_PERIOD(STEP_HALF_PERIOD),
        .RAMP_START_HALF (RAMP_START_HALF),
        .RAMP_DEC        (RAMP_DEC),
        .PH_W            (PH_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load_c),
        .load_step(tmr_load_step_c),
        .load_val (tmr_val_c),
        .ramp_rst (ramp_rst_c),
        .ramp_adv (ramp_adv_c),
        .expired_c(tmr_exp_c)
    );

    // Next-state, latched move fields and next values of the registered pins.
    always_comb begin
        state_d         = state_q;
        face_d          = face_q;
        dir_d           = dir_q;
        turn_half_d     = turn_half_q;
        steps_d         = steps_q;
        err_d           = 1'b0;
        abort_d         = 1'b0;
        tmr_load_c      = 1'b0;
        tmr_load_step_c = 1'b0;
        tmr_val_c       = '0;
        ramp_rst_c      = 1'b0;
        ramp_adv_c      = 1'b0;
        step_tgt_c      = STEP_W'(move_steps(turn_half_q, QUARTER_STEPS));
        steps_inc_c     = steps_q + STEP_W'(1);

        case (state_q)
            IDLE: begin
                if (move_valid && move_ready) begin
                    face_d      = move_face;
                    dir_d       = ~move_ccw;
                    turn_half_d = move_half;
                    steps_d     = '0;
                    if (32'(move_face) >= NUM_FACES) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = SETUP;
                        tmr_load_c = 1'b1;
                        tmr_val_c  = PH_W'(EN_SETUP);
                    end
                end
            end
            SETUP: begin
                if (tmr_exp_c) begin
                    state_d         = STEP_HI;
                    tmr_load_c      = 1'b1;
                    tmr_load_step_c = 1'b1;
                    ramp_rst_c      = 1'b1;
                end
            end
            STEP_HI: begin
                if (tmr_exp_c) begin
                    state_d         = STEP_LO;
                    tmr_load_c      = 1'b1;
                    tmr_load_step_c = 1'b1;
                end
            end
            STEP_LO: begin
                if (tmr_exp_c) begin
                    steps_d    = steps_inc_c;
                    tmr_load_c = 1'b1;
                    if (steps_inc_c == step_tgt_c) begin
                        state_d   = SETTLE;
                        tmr_val_c = PH_W'(SETTLE_CYCLES);
                    end else begin
                        state_d         = STEP_HI;
                        tmr_load_step_c = 1'b1;
                        ramp_adv_c      = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (tmr_exp_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable wins over any in-flight progress.
        if (disable_steppers && (state_q inside {SETUP, STEP_HI, STEP_LO, SETTLE})) begin
            state_d    = DONE;
            abort_d    = 1'b1;
            tmr_load_c = 1'b0;
            ramp_rst_c = 1'b0;
            ramp_adv_c = 1'b0;
        end

        en_d   = (state_d inside {SETUP, STEP_HI, STEP_LO, SETTLE}) ?
                 (NUM_FACES'(1) << face_d) : '0;
        step_d = (state_d == STEP_HI);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            face_q      <= '0;
            dir_q       <= 1'b0;
            turn_half_q <= 1'b0;
            steps_q     <= '0;
            en_q        <= '0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            face_q      <= face_d;
            dir_q       <= dir_d;
            turn_half_q <= turn_half_d;
            steps_q     <= steps_d;
            en_q        <= en_d;
            step_q      <= step_d;
            done_q      <= done_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
        end
    end

    assign en_pins      = en_q;
    assign step_pin     = step_q;
    assign dir_pin      = dir_q;
    assign move_done    = done_q;
    assign move_err     = err_q;
    assign move_aborted = abort_q;

endmodule

// File: tb/tb_face_move_sequencer.sv
// Self-checking bench for face_move_sequencer with small timing parameters;
// expected pin traces come from closed-form timing of each move.
module tb_face_move_sequencer;

    localparam int NF = 6;
    localparam int QS = 4;
    localparam int HP = 3;
    localparam int ES = 2;
    localparam int SC = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          disable_steppers = 1'b0;
    logic          move_valid = 1'b0;
    logic [2:0]    move_face = '0;
    logic          move_ccw = 1'b0;
    logic          move_half = 1'b0;
    logic          move_ready, move_done, move_err, move_aborted;
    logic          dir_pin, step_pin;
    logic [NF-1:0] en_pins;

    int errors = 0;
    int checks = 0;

    face_move_sequencer #(
        .NUM_FACES       (NF),
        .QUARTER_STEPS   (QS),
        .STEP_HALF_PERIOD(HP),
        .RAMP_START_HALF (9),
        .RAMP_DEC        (3),
        .EN_SETUP        (ES),
        .SETTLE_CYCLES   (SC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .disable_steppers(disable_steppers),
        .move_valid      (move_valid),
        .move_face       (move_face),
        .move_ccw        (move_ccw),
        .move_half       (move_half),
        .move_ready      (move_ready),
        .move_done       (move_done),
        .move_err        (move_err),
        .move_aborted    (move_aborted),
        .dir_pin         (dir_pin),
        .step_pin        (step_pin),
        .en_pins         (en_pins)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step pin at cycle t after accept: pulses begin after enable setup, each
    // pulse is HP high then HP low.
    function automatic logic model_step(input int t, input int n);
        int s;
        s = t - (1 + ES);
        if (s < 0 || s >= 2 * n * HP) return 1'b0;
        return ((s / HP) % 2) == 0;
    endfunction

    function automatic int model_latency(input bit bad, input int n);
        return bad ? 1 : 1 + ES + 2 * n * HP + SC;
    endfunction

    // Issue one move and compare every output cycle by cycle until idle again.
    // With noise set, move_valid is held high during the move and must be ignored.
    task automatic run_move(input int face, input bit ccw, input bit half, input bit noise);
        bit            bad;
        int            n, lat, edges;
        logic [NF-1:0] oh;
        logic          prev;
        bad   = (face >= NF);
        n     = half ? 2 * QS : QS;
        lat   = model_latency(bad, n);
        oh    = bad ? '0 : NF'(1) << face;
        edges = 0;
        prev  = 1'b0;
        @(negedge clock);
        move_valid = 1'b1;
        move_face  = 3'(face);
        move_ccw   = ccw;
        move_half  = half;
        check("ready_before_accept", 32'(move_ready), 32'd1);
        @(posedge clock);
        for (int t = 1; t <= lat + 1; t++) begin
            @(negedge clock);
            move_valid = noise && (t >= 1) && (t < lat - 1);
            if (noise) move_face = 3'($urandom_range(0, 7));
            check("en_pins", 32'(en_pins), (t < lat) ? 32'(oh) : 32'd0);
            check("step_pin", 32'(step_pin), bad ? 32'd0 : 32'(model_step(t, n)));
            check("move_done", 32'(move_done), 32'(t == lat));
            check("move_err", 32'(move_err), 32'(bad && t == lat));
            check("move_aborted", 32'(move_aborted), 32'd0);
            check("move_ready", 32'(move_ready), 32'(t == lat + 1));
            if (!bad && t < lat) check("dir_pin", 32'(dir_pin), 32'(!ccw));
            if (step_pin && !prev) edges++;
            prev = step_pin;
        end
        check("step_edges", 32'(edges), bad ? 32'd0 : 32'(n));
        move_valid = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_en", 32'(en_pins), 32'd0);
        check("rst_step", 32'(step_pin), 32'd0);
        check("rst_done", 32'(move_done), 32'd0);
        check("rst_ready", 32'(move_ready), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1 check("idle_ready", 32'(move_ready), 32'd1);

        // Directed moves: quarter CW on UP, half CCW on DOWN, bad face index.
        run_move(1, 1'b0, 1'b0, 1'b0);
        run_move(5, 1'b1, 1'b1, 1'b0);
        run_move(7, 1'b0, 1'b0, 1'b0);
        run_move(3, 1'b1, 1'b0, 1'b1);

        // Abort during the third pulse high phase.
        @(negedge clock);
        move_valid = 1'b1; move_face = 3'd2; move_ccw = 1'b0; move_half = 1'b0;
        @(posedge clock);
        for (int t = 1; t <= 16; t++) begin
            @(negedge clock);
            move_valid = 1'b0;
            check("abort_pre_en", 32'(en_pins), 32'(NF'(1) << 2));
            check("abort_pre_step", 32'(step_pin), 32'(model_step(t, QS)));
        end
        disable_steppers = 1'b1;
        @(negedge clock);
        check("abort_en", 32'(en_pins), 32'd0);
        check("abort_step", 32'(step_pin), 32'd0);
        check("abort_done", 32'(move_done), 32'd1);
        check("abort_flag", 32'(move_aborted), 32'd1);
        check("abort_err", 32'(move_err), 32'd0);
        for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            check("abort_hold_ready", 32'(move_ready), 32'd0);
            check("abort_hold_done", 32'(move_done), 32'd0);
            check("abort_hold_en", 32'(en_pins), 32'd0);
        end
        disable_steppers = 1'b0;
        #1 check("abort_release_ready", 32'(move_ready), 32'd1);

        // Reset in the middle of the first step high phase.
        @(negedge clock);
        move_valid = 1'b1; move_face = 3'd0; move_ccw = 1'b1; move_half = 1'b1;
        @(posedge clock);
        for (int t = 1; t <= 4; t++) begin
            @(negedge clock);
            move_valid = 1'b0;
            check("prerst_step", 32'(step_pin), 32'(model_step(t, 2 * QS)));
        end
        reset = 1'b1;
        #1;
        check("midrst_en", 32'(en_pins), 32'd0);
        check("midrst_step", 32'(step_pin), 32'd0);
        check("midrst_dir", 32'(dir_pin), 32'd0);
        check("midrst_ready", 32'(move_ready), 32'd0);
        check("midrst_flags", 32'({move_done, move_err, move_aborted}), 32'd0);
        repeat (3) begin
            @(negedge clock);
            check("midrst_no_done", 32'(move_done), 32'd0);
        end
        reset = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            check("postrst_no_done", 32'(move_done), 32'd0);
            check("postrst_ready", 32'(move_ready), 32'd1);
        end
        run_move(4, 1'b0, 1'b1, 1'b0);

        // Random moves, including occasional out-of-range faces.
        for (int i = 0; i < 8; i++) begin
            run_move(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
